// File: rtl/ring_counter_monitor.sv
// ring_counter_monitor
// Receive-side checker for a free-running one-hot ring counter bus.
// It acquires lock on the rotation sequence and reports the binary index of
// the hot bit. It also flags and counts sequence errors, and it drops lock
// after repeated misses.
//
// Ports
//   clk     : single clock, rising edge
//   clr_n   : asynchronous active-low reset
//   en      : counter advances on this edge (sampled together with q)
//   q       : N-bit ring counter output
//   idx     : binary position of the hot bit in the last legal sample
//   valid   : last sample was legal (exactly one bit set)
//   locked  : monitor is tracking the sequence
//   err     : one-cycle pulse on a mismatch while locked
//   wrap    : one-cycle pulse when the locked sequence returns to the start pattern
//   err_cnt : saturating mismatch count, cleared only by reset
module ring_counter_monitor #(
    parameter int N        = 3,
    parameter bit DIR      = 1'b0,
    parameter int LOCK_CNT = 2,
    parameter int MISS_MAX = 2,
    localparam int IW      = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    input  logic [N-1:0]  q,
    output logic [IW-1:0] idx,
    output logic          valid,
    output logic          locked,
    output logic          err,
    output logic          wrap,
    output logic [7:0]    err_cnt
);

    localparam int RW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int MW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);
    localparam logic [N-1:0] START = DIR ? {1'b1, {(N-1){1'b0}}} : {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         st_reg, st_next;
    logic [N-1:0]   exp_reg, exp_next;
    logic [N-1:0]   prev_reg, prev_next;
    logic [RW-1:0]  run_reg, run_next;
    logic [MW-1:0]  miss_reg, miss_next;
    logic [IW-1:0]  idx_reg, idx_next;
    logic           valid_reg, valid_next;
    logic           locked_reg, locked_next;
    logic           err_reg, err_next;
    logic           wrap_reg, wrap_next;
    logic [7:0]     err_cnt_reg, err_cnt_next;

    logic           legal;
    logic           match;

    // One step of rotation in the configured direction, wrapping at the ends.
    function automatic logic [N-1:0] rot(input logic [N-1:0] p);
        if (DIR)
            return {p[0], p[N-1:1]};
        else
            return {p[N-2:0], p[N-1]};
    endfunction

    // Predicted next sample: the counter only moves when en was high.
    function automatic logic [N-1:0] nxt(input logic [N-1:0] p, input logic adv);
        return adv ? rot(p) : p;
    endfunction

    function automatic logic [IW-1:0] enc(input logic [N-1:0] p);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (p[i])
                r = IW'(i);
        return r;
    endfunction

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign legal = (q != '0) && ((q & (q - 1'b1)) == '0);
    assign match = (q == exp_reg);

    always_comb begin
        st_next      = st_reg;
        exp_next     = exp_reg;
        prev_next    = q;
        run_next     = run_reg;
        miss_next    = miss_reg;
        idx_next     = legal ? enc(q) : idx_reg;
        valid_next   = legal;
        err_next     = 1'b0;
        wrap_next    = 1'b0;
        err_cnt_next = err_cnt_reg;

        unique case (st_reg)
            SEARCH: begin
                if (legal) begin
                    exp_next = nxt(q, en);
                    run_next = '0;
                    st_next  = SYNC;
                end
            end
            SYNC: begin
                if (match) begin
                    exp_next = nxt(q, en);
                    run_next = run_reg + 1'b1;
                    if (32'(run_reg) + 32'd1 == 32'(LOCK_CNT)) begin
                        st_next   = LOCKED;
                        miss_next = '0;
                    end
                end else if (legal) begin
                    exp_next = nxt(q, en);
                    run_next = '0;
                end else begin
                    st_next = SEARCH;
                end
            end
            LOCKED: begin
                if (match) begin
                    exp_next  = nxt(q, en);
                    miss_next = '0;
                    // A held counter (q unchanged) must not re-fire wrap.
                    wrap_next = (q == START) && (q != prev_reg);
                end else begin
                    err_next     = 1'b1;
                    err_cnt_next = (err_cnt_reg == 8'hFF) ? err_cnt_reg : err_cnt_reg + 8'd1;
                    // Keep predicting the free-running sequence through a glitch.
                    exp_next     = nxt(exp_reg, en);
                    miss_next    = miss_reg + 1'b1;
                    if (32'(miss_reg) + 32'd1 == 32'(MISS_MAX))
                        st_next = SEARCH;
                end
            end
            default: begin
                st_next = SEARCH;
            end
        endcase

        locked_next = (st_next == LOCKED);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st_reg      <= SEARCH;
            exp_reg     <= '0;
            prev_reg    <= '0;
            run_reg     <= '0;
            miss_reg    <= '0;
            idx_reg     <= '0;
            valid_reg   <= 1'b0;
            locked_reg  <= 1'b0;
            err_reg     <= 1'b0;
            wrap_reg    <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            st_reg      <= st_next;
            exp_reg     <= exp_next;
            prev_reg    <= prev_next;
            run_reg     <= run_next;
            miss_reg    <= miss_next;
            idx_reg     <= idx_next;
            valid_reg   <= valid_next;
            locked_reg  <= locked_next;
            err_reg     <= err_next;
            wrap_reg    <= wrap_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign idx     = idx_reg;
    assign valid   = valid_reg;
    assign locked  = locked_reg;
    assign err     = err_reg;
    assign wrap    = wrap_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Testbench for ring_counter_monitor (N=3, DIR=0, LOCK_CNT=2, MISS_MAX=2).
// It applies a table of directed samples with hand-computed expected outputs.
// Hand-written sequences then cover reset release, err_cnt saturation and an
// asynchronous reset asserted mid-cycle.
module tb_ring_counter_monitor;

    logic       clk;
    logic       clr_n;
    logic       en;
    logic [2:0] q;
    logic [1:0] idx;
    logic       valid;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] err_cnt;

    int n_checks;
    int n_pass;

    ring_counter_monitor #(
        .N(3), .DIR(1'b0), .LOCK_CNT(2), .MISS_MAX(2)
    ) dut (
        .clk(clk), .clr_n(clr_n), .en(en), .q(q),
        .idx(idx), .valid(valid), .locked(locked),
        .err(err), .wrap(wrap), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] q;
        logic       valid;
        logic [1:0] idx;
        logic       locked;
        logic       err;
        logic       wrap;
        logic [7:0] err_cnt;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [1:0] i, input logic l,
                           input logic e, input logic w, input logic [7:0] c);
        chk({tag, ".valid"},   32'(valid),   32'(v));
        chk({tag, ".idx"},     32'(idx),     32'(i));
        chk({tag, ".locked"},  32'(locked),  32'(l));
        chk({tag, ".err"},     32'(err),     32'(e));
        chk({tag, ".wrap"},    32'(wrap),    32'(w));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(c));
    endtask

    function automatic logic [2:0] rot3(input logic [2:0] p);
        return {p[1:0], p[2]};
    endfunction

    initial begin
        logic [2:0] e_pat;
        logic [7:0] cnt_model;
        n_checks = 0;
        n_pass   = 0;

        //            en    q     valid idx  lock err  wrap cnt
        // Acquire
        vecs[0]  = '{1'b1, 3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 3'b010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 3'b100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 3'b001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd0};
        // Hold at 010 with en=0, then advance
        vecs[4]  = '{1'b0, 3'b010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 3'b010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 3'b010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 3'b010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 3'b100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[9]  = '{1'b1, 3'b001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[10] = '{1'b1, 3'b010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0};
        // Single glitch: 011 in place of 100, then 001
        vecs[11] = '{1'b1, 3'b011, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 3'b001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd1};
        // Loss of lock after two 000 samples, then re-lock
        vecs[13] = '{1'b1, 3'b000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd2};
        vecs[14] = '{1'b1, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[15] = '{1'b1, 3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd3};
        vecs[16] = '{1'b1, 3'b010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd3};
        vecs[17] = '{1'b1, 3'b100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[18] = '{1'b1, 3'b001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd3};
        // Mismatch that is also the start pattern: err=1, wrap=0
        vecs[19] = '{1'b1, 3'b001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd4};
        vecs[20] = '{1'b1, 3'b100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'd4};

        // Reset held for two edges
        clr_n = 1'b0;
        en    = 1'b1;
        q     = 3'b001;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        $display("reset held: valid=%0b locked=%0b err_cnt=%0d", valid, locked, err_cnt);
        // Release between edges: nothing changes until the next edge
        #1 clr_n = 1'b1;
        #1;
        chk("release.valid", 32'(valid), 32'd0);
        chk("release.idx",   32'(idx),   32'd0);

        foreach (vecs[k]) begin
            @(negedge clk);
            en = vecs[k].en;
            q  = vecs[k].q;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", k), vecs[k].valid, vecs[k].idx, vecs[k].locked,
                    vecs[k].err, vecs[k].wrap, vecs[k].err_cnt);
            $display("vec%0d en=%0b q=%b -> idx=%0d valid=%0b locked=%0b err=%0b wrap=%0b err_cnt=%0d",
                     k, en, q, idx, valid, locked, err, wrap, err_cnt);
        end

        // Saturation: 300 isolated mismatches, each followed by a correct
        // sample so the miss counter clears and lock is kept.
        e_pat     = 3'b001;
        cnt_model = 8'd4;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            en = 1'b1;
            q  = 3'b000;
            @(posedge clk);
            #1;
            e_pat = rot3(e_pat);
            if (cnt_model != 8'hFF)
                cnt_model = cnt_model + 8'd1;
            chk("sat.err",     32'(err),     32'd1);
            chk("sat.err_cnt", 32'(err_cnt), 32'(cnt_model));
            @(negedge clk);
            q = e_pat;
            @(posedge clk);
            #1;
            e_pat = rot3(e_pat);
            chk("sat.locked", 32'(locked), 32'd1);
            chk("sat.err0",   32'(err),    32'd0);
            if (g % 50 == 49)
                $display("sat burst %0d: err_cnt=%0d locked=%0b", g + 1, err_cnt, locked);
        end
        chk("sat.final", 32'(err_cnt), 32'd255);

        // Asynchronous reset mid-cycle while locked
        #2;
        chk("pre_rst.locked", 32'(locked), 32'd1);
        clr_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        $display("async reset: valid=%0b locked=%0b err_cnt=%0d", valid, locked, err_cnt);
        #10 clr_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
